// File: rtl/cmp_unit_seq_if.sv
// rtl/cmp_unit_seq_if.sv - request/result bundle for the sliced compare unit
interface cmp_unit_seq_if #(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 8
);
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2:0]           ALU_FUN;
  logic                 SIGNED_EN;
  logic                 IN_VALID;
  logic                 IN_READY;
  logic                 BUSY;
  logic [OUT_WIDTH-1:0] CMP_OUT;
  logic                 OUT_VALID;

  modport master (
    output A, B, ALU_FUN, SIGNED_EN, IN_VALID,
    input  IN_READY, BUSY, CMP_OUT, OUT_VALID
  );

  modport slave (
    input  A, B, ALU_FUN, SIGNED_EN, IN_VALID,
    output IN_READY, BUSY, CMP_OUT, OUT_VALID
  );
endinterface

// File: rtl/cmp_unit_seq.sv
// rtl/cmp_unit_seq.sv - multi-cycle MSB-first sliced compare unit with early termination
module cmp_unit_seq #(
  parameter int WIDTH     = 16,
  parameter int SLICE     = 4,
  parameter int OUT_WIDTH = 8,
  parameter int FUN_WIDTH = 3
) (
  input  logic          CLK,
  input  logic          RST,
  cmp_unit_seq_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2:0]           fun_q, fun_d;
  logic [OUT_WIDTH-1:0] cmp_q, cmp_d;
  logic                 ov_q, ov_d;
  logic [SLICE-1:0]     a_top, b_top;
  logic                 sl_gt, sl_lt;

  function automatic logic [2:0] result_code(input logic [2:0] fun,
                                             input logic gt, input logic lt);
    logic eq;
    eq = !gt && !lt;
    case (fun)
      3'd1:    result_code = eq  ? 3'd1 : 3'd0;
      3'd2:    result_code = gt  ? 3'd2 : 3'd0;
      3'd3:    result_code = lt  ? 3'd3 : 3'd0;
      3'd4:    result_code = !eq ? 3'd4 : 3'd0;
      3'd5:    result_code = !lt ? 3'd5 : 3'd0;
      3'd6:    result_code = !gt ? 3'd6 : 3'd0;
      default: result_code = 3'd0;
    endcase
  endfunction

  // Captured operands shift left each step, so the slice under test is always the top one.
  assign a_top = a_q[WIDTH-1 -: SLICE];
  assign b_top = b_q[WIDTH-1 -: SLICE];
  assign sl_gt = a_top > b_top;
  assign sl_lt = a_top < b_top;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    fun_d   = fun_q;
    cmp_d   = cmp_q;
    ov_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.IN_VALID) begin
          state_d = SCAN;
          idx_d   = IDX_W'(NSLICE - 1);
          a_d     = bus.A;
          b_d     = bus.B;
          fun_d   = bus.ALU_FUN;
          // Flipping both sign bits maps two's-complement order onto unsigned order.
          if (bus.SIGNED_EN) begin
            a_d[WIDTH-1] = ~bus.A[WIDTH-1];
            b_d[WIDTH-1] = ~bus.B[WIDTH-1];
          end
        end
      end
      SCAN: begin
        if (sl_gt || sl_lt || (idx_q == '0)) begin
          cmp_d   = OUT_WIDTH'(result_code(fun_q, sl_gt, sl_lt));
          ov_d    = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
          a_d   = a_q << SLICE;
          b_d   = b_q << SLICE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= '0;
      cmp_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      cmp_q   <= cmp_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.IN_READY  = (state_q == IDLE);
  assign bus.BUSY      = (state_q != IDLE);
  assign bus.CMP_OUT   = cmp_q;
  assign bus.OUT_VALID = ov_q;
endmodule

// File: doc/cmp_unit_seq.md
# cmp_unit_seq

Parametrised, multi-cycle successor to the single-cycle ALU compare unit. Captures two WIDTH-bit operands with a valid/ready handshake and compares them SLICE bits per cycle, MSB slice first. It terminates early on the first differing slice and supports both signed and unsigned comparison. It extends the function set with NE, GE and LE, keeps result codes 1/2/3 for EQ/GT/LT, and sits in the ALU compare path where wide operands would otherwise break single-cycle timing.

## Interface
- WIDTH, 16, operand width in bits; must be an integer multiple of SLICE.
- SLICE, 4, bits compared per scan cycle. NSLICE = WIDTH/SLICE, and NSLICE ≥ 1.
- OUT_WIDTH, 8, result width; must be ≥ 3.
- FUN_WIDTH, 3, function code width; fixed at 3.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- A  in  WIDTH  operand A; sampled only on acceptance.
- B  in  WIDTH  operand B; sampled only on acceptance.
- ALU_FUN  in  3  function code; sampled on acceptance.
- SIGNED_EN  in  1  1 = two's-complement compare, 0 = unsigned; sampled on acceptance.
- IN_VALID  in  1  request valid.
- IN_READY  out  1  unit can accept; equals (state == IDLE).
- BUSY  out  1  equals !IN_READY.
- CMP_OUT  out  OUT_WIDTH  registered result; holds the last result until the next one.
- OUT_VALID  out  1  one-cycle pulse marking a new CMP_OUT.

## Operation
- Function codes and the value loaded into CMP_OUT. Upper bits are always zero-extended.
  - 000: reserved, result 0.
  - 001: EQ, result 1 if A==B, else 0.
  - 010: GT, result 2 if A>B, else 0.
  - 011: LT, result 3 if A<B, else 0.
  - 100: NE, result 4 if A!=B, else 0.
  - 101: GE, result 5 if A>=B, else 0.
  - 110: LE, result 6 if A<=B, else 0.
  - 111: reserved, result 0.
- Reserved codes still run a full handshake and produce OUT_VALID with result 0.
- Acceptance occurs at a rising edge with IN_VALID=1 and IN_READY=1. At that edge the unit latches A, B, ALU_FUN and SIGNED_EN into internal registers.
- When SIGNED_EN=1, the MSB of both captured operands is inverted at capture. This makes the unsigned slice scan give the signed ordering.
- The unit ignores the inputs while BUSY. Later changes to A, B, ALU_FUN or SIGNED_EN do not affect an in-flight compare.
- FSM states are IDLE and SCAN, with a slice index idx of width clog2(NSLICE), minimum 1 bit.
  - IDLE: IN_READY=1. On acceptance, go to SCAN with idx = NSLICE-1.
  - SCAN: compare captured slices A[idx] and B[idx].
    - If A[idx] > B[idx], the relation is GT. If A[idx] < B[idx], the relation is LT. In either case, load CMP_OUT from the relation and function code, pulse OUT_VALID, and go to IDLE.
    - Else, if idx == 0, the relation is EQ. Load CMP_OUT, pulse OUT_VALID, and go to IDLE.
    - Else, decrement idx and stay in SCAN.
- Unit throughput is one transaction in flight at a time.

## Timing
- Reset values (asynchronous, while RST=0):
  - CMP_OUT = 0, OUT_VALID = 0.
  - State = IDLE, so IN_READY = 1 and BUSY = 0.
  - idx and captured registers = 0.
- Reset asserted mid-SCAN aborts the transaction. No OUT_VALID is produced for it. After release, the first acceptance edge starts a fresh compare.
- Latency is counted from acceptance edge E0. If the first differing slice is index j, CMP_OUT and OUT_VALID update at edge E(NSLICE-j).
  - Best case, MSB slice differs: 1 cycle.
  - Worst case, equal operands or only slice 0 differs: NSLICE cycles.
- OUT_VALID is high for exactly one cycle after the result edge. There is no output backpressure.
- The FSM re-enters IDLE on the same edge that loads the result. IN_READY is therefore high in the same cycle as OUT_VALID, and a back-to-back acceptance is legal at the next edge.
- IN_VALID held high while BUSY produces no capture. The request is taken at the first edge at which IN_READY=1.
- NSLICE = 1 (SLICE = WIDTH) degenerates to a fixed 1-cycle latency.

## Test plan
Parameters for all scenarios: WIDTH=16, SLICE=4.
- **Reset:** assert RST=0 mid-stream → CMP_OUT=0, OUT_VALID=0, IN_READY=1 immediately, without waiting for a clock edge.
- **Equal operands, worst-case latency:** A=B=0x1234, ALU_FUN=001 → CMP_OUT=1 with OUT_VALID at E0+4.
  - Same operands with NE (100) → CMP_OUT=0 at E0+4.
- **Sign mode on the MSB slice:** A=0x8000, B=0x7FFF, ALU_FUN=010.
  - SIGNED_EN=0 → CMP_OUT=2 at E0+1.
  - SIGNED_EN=1 → CMP_OUT=0 at E0+1.
  - SIGNED_EN=1 with ALU_FUN=011 → CMP_OUT=3 at E0+1.
- **LSB-slice decision:** A=0x00F0, B=0x00F1, unsigned.
  - ALU_FUN=011 → CMP_OUT=3 at E0+4.
  - ALU_FUN=101 → CMP_OUT=0 at E0+4.
  - ALU_FUN=110 → CMP_OUT=6 at E0+4.
- **Handshake and capture isolation:** accept A=0x0100, B=0x0200 (LT). Then change A/B to 0xFFFF/0x0000 with IN_VALID held high during BUSY.
  - First result: CMP_OUT=3 at E0+2, computed from the original operands.
  - Second request accepted at the edge after that → CMP_OUT=0 at E+1 for the LT function.
- **Reserved code and mid-scan reset:** ALU_FUN=111 with equal operands → CMP_OUT=0, OUT_VALID pulse at E0+4.
  - Assert RST at E0+2 of an equal-operand compare → no OUT_VALID for that transaction, and the next transaction completes normally.
